// File: rtl/vdf_seq_sched_if.sv
// Bundle of request, detector and response signals between vdf_seq_sched
// and its surroundings. The scheduler side uses the slave modport.
interface vdf_seq_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  det_reset;
  logic                  det_data_in;
  logic                  det_data_out;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [CNTW-1:0]       rsp_hits;
  logic                  rsp_ready;
  logic                  busy;

  modport slave (
    input  req_valid, req_data, det_data_out, rsp_ready,
    output req_ready, det_reset, det_data_in, rsp_valid, rsp_id, rsp_hits, busy
  );

  modport master (
    output req_valid, req_data, det_data_out, rsp_ready,
    input  req_ready, det_reset, det_data_in, rsp_valid, rsp_id, rsp_hits, busy
  );
endinterface

// File: rtl/vdf_seq_sched.sv
// Round-robin scheduler time-sharing one bit-serial sequence detector among
// NREQ requesters; each word is shifted in MSB first and its hits counted.
module vdf_seq_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic clk,
  input  logic reset,
  vdf_seq_sched_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BCW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr, id_r, grant;
  logic            found;
  logic [WIDTH-1:0] sreg;
  logic [BCW-1:0]  bcnt;
  logic [CNTW-1:0] hits, hits_inc;

  function automatic logic [IDW-1:0] wrap(input logic [IDW-1:0] p, input int k);
    int j;
    j = int'(p) + k;
    if (j >= NREQ) j = j - NREQ;
    return IDW'(j);
  endfunction

  // Scan from the highest offset down so the nearest valid to rr_ptr wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap(rr_ptr, k)]) begin
        grant = wrap(rr_ptr, k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && found && !reset) bus.req_ready = NREQ'(1) << grant;
  end

  assign bus.busy = (state != IDLE);
  assign hits_inc = (&hits) ? hits : hits + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      id_r            <= '0;
      sreg            <= '0;
      bcnt            <= '0;
      hits            <= '0;
      bus.det_reset   <= 1'b1;
      bus.det_data_in <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_id      <= '0;
      bus.rsp_hits    <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.det_reset <= 1'b0;
          if (found) begin
            sreg            <= bus.req_data[grant*WIDTH +: WIDTH];
            id_r            <= grant;
            rr_ptr          <= wrap(grant, 1);
            bus.det_reset   <= 1'b1;
            bus.det_data_in <= 1'b0;
            state           <= CLR;
          end
        end
        CLR: begin
          bus.det_reset   <= 1'b0;
          hits            <= '0;
          bcnt            <= '0;
          bus.det_data_in <= sreg[WIDTH-1];
          sreg            <= sreg << 1;
          state           <= SHIFT;
        end
        SHIFT: begin
          // First SHIFT sample still reflects the cleared detector; skip it.
          if (bcnt != '0 && bus.det_data_out) hits <= hits_inc;
          if (bcnt == BCW'(WIDTH - 1)) begin
            bus.det_data_in <= 1'b0;
            state           <= DRAIN;
          end else begin
            bus.det_data_in <= sreg[WIDTH-1];
            sreg            <= sreg << 1;
            bcnt            <= bcnt + 1'b1;
          end
        end
        DRAIN: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_id    <= id_r;
          bus.rsp_hits  <= bus.det_data_out ? hits_inc : hits;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vdf_seq_sched.sv
// Bench for vdf_seq_sched: delay-line stub detector (hits = popcount),
// transaction-level reference model checked every cycle, plus directed cases.
module tb_vdf_seq_sched;
  localparam int NREQ = 4, WIDTH = 8, CNTW = 4, IDW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vdf_seq_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) bus();
  vdf_seq_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (.clk(clk), .reset(reset), .bus(bus));

  vdf_seq_sched_if #(.NREQ(2), .WIDTH(8), .CNTW(2)) sbus();
  vdf_seq_sched #(.NREQ(2), .WIDTH(8), .CNTW(2)) sdut (.clk(clk), .reset(reset), .bus(sbus));

  logic stub, sstub;
  always @(posedge clk or posedge reset)
    if (reset) stub <= 1'b0; else stub <= bus.det_reset ? 1'b0 : bus.det_data_in;
  always @(posedge clk or posedge reset)
    if (reset) sstub <= 1'b0; else sstub <= sbus.det_reset ? 1'b0 : sbus.det_data_in;
  assign bus.det_data_out  = stub;
  assign sbus.det_data_out = sstub;

  int errs = 0, checks = 0;
  bit chk_on = 1'b0;
  int cycn = 0;
  always @(posedge clk) cycn <= cycn + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycn);
    end
  endtask

  function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [CNTW-1:0] sat_pop(input logic [WIDTH-1:0] w);
    int n;
    n = $countones(w);
    return (n > (1 << CNTW) - 1) ? CNTW'((1 << CNTW) - 1) : CNTW'(n);
  endfunction

  // Reference model: time since acceptance drives everything.
  bit m_busy, m_rsp, m_after_rst;
  int m_t, m_rr;
  logic [WIDTH-1:0] m_word;
  logic [IDW-1:0] m_id, m_rid;
  logic [CNTW-1:0] m_hits, m_rhits;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_rsp <= 0; m_after_rst <= 1; m_t <= 0; m_rr <= 0;
      m_rid <= '0; m_rhits <= '0;
    end else begin
      m_after_rst <= 0;
      if (m_rsp) begin
        if (bus.rsp_ready) begin m_rsp <= 0; m_busy <= 0; end
      end else if (m_busy) begin
        if (m_t == WIDTH + 2) begin
          m_rsp <= 1; m_rid <= m_id; m_rhits <= m_hits;
        end else m_t <= m_t + 1;
      end else if (pick(m_rr, bus.req_valid) >= 0) begin
        m_busy <= 1;
        m_t    <= 1;
        m_word <= bus.req_data[pick(m_rr, bus.req_valid)*WIDTH +: WIDTH];
        m_id   <= IDW'(pick(m_rr, bus.req_valid));
        m_hits <= sat_pop(bus.req_data[pick(m_rr, bus.req_valid)*WIDTH +: WIDTH]);
        m_rr   <= (pick(m_rr, bus.req_valid) + 1) % NREQ;
      end
    end
  end

  function automatic logic [NREQ-1:0] exp_ready();
    if (reset || m_busy || pick(m_rr, bus.req_valid) < 0) return '0;
    return NREQ'(1) << pick(m_rr, bus.req_valid);
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready()));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("det_reset", 32'(bus.det_reset), 32'(m_after_rst || (m_busy && !m_rsp && m_t == 1)));
      chk("det_data_in", 32'(bus.det_data_in),
          (m_busy && !m_rsp && m_t >= 2 && m_t <= WIDTH + 1) ? 32'(m_word[WIDTH+1-m_t]) : 32'd0);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp));
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_rid));
      chk("rsp_hits", 32'(bus.rsp_hits), 32'(m_rhits));
    end
  end

  // Transaction log of accepts and response handshakes.
  int g_id[$], g_cyc[$], r_id[$], r_hits[$], r_cyc[$];
  logic [NREQ-1:0] acc_mask = '0;
  logic [NREQ-1:0] hold_mask = '0;
  always @(negedge clk) begin
    acc_mask <= '0;
    if (!reset) begin
      if (|(bus.req_ready & bus.req_valid)) begin
        acc_mask <= bus.req_ready & bus.req_valid;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i] && bus.req_valid[i]) begin
          g_id.push_back(i); g_cyc.push_back(cycn);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        r_id.push_back(int'(bus.rsp_id)); r_hits.push_back(int'(bus.rsp_hits)); r_cyc.push_back(cycn);
      end
    end
  end

  // Advance one clock; accepted one-shot requests drop their valid.
  task automatic cyc();
    @(posedge clk);
    #1 bus.req_valid = bus.req_valid & ~(acc_mask & ~hold_mask);
    #1;
  endtask

  task automatic wait_grant(input int n, input string nm);
    int k = 0;
    while (g_id.size() < n && k < 200) begin cyc(); k++; end
    chk({nm, "_grant_seen"}, 32'(g_id.size() >= n), 32'd1);
  endtask

  task automatic wait_rsp(input int n, input string nm);
    int k = 0;
    while (r_id.size() < n && k < 200) begin cyc(); k++; end
    chk({nm, "_rsp_seen"}, 32'(r_id.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
  endtask

  initial begin
    int n, n0, nr, k;
    logic [7:0] seq;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int exp_h[5] = '{1, 2, 3, 4, 1};

    bus.req_valid = '0; bus.req_data = '0; bus.rsp_ready = 1'b0;
    sbus.req_valid = '0; sbus.req_data = '0; sbus.rsp_ready = 1'b0;
    #1 reset = 1'b1;
    chk_on = 1'b1;
    repeat (2) cyc();

    // Reset values; req_ready masked while reset is held
    chk("rst_det_reset", 32'(bus.det_reset), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    bus.req_valid = 4'b0001;
    #1 chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    reset = 1'b0;
    cyc();
    chk("det_reset_fall", 32'(bus.det_reset), 32'd0);

    // Single word 0xB5 from requester 0
    bus.req_data[7:0] = 8'hB5; bus.rsp_ready = 1'b1; bus.req_valid = 4'b0001;
    wait_grant(1, "s1");
    chk("s1_clr_det_reset", 32'(bus.det_reset), 32'd1);
    for (int b = 0; b < 8; b++) begin cyc(); seq[7-b] = bus.det_data_in; end
    chk("s1_bits", 32'(seq), 32'hB5);
    n = 8;
    while (!bus.rsp_valid && n < 40) begin cyc(); n++; end
    chk("s1_latency", 32'(n), 32'd10);
    chk("s1_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("s1_rsp_hits", 32'(bus.rsp_hits), 32'd5);
    cyc();

    // Round-robin from a fresh pointer, all requesters held valid
    do_reset();
    n0 = g_id.size(); nr = r_id.size();
    hold_mask = 4'hF;
    bus.req_data = 32'h0F070301;
    bus.req_valid = 4'hF;
    wait_grant(n0 + 5, "rr");
    bus.req_valid = '0; hold_mask = '0;
    wait_rsp(nr + 5, "rr");
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", 32'(g_id[n0+i]), 32'(exp_g[i]));
      chk("rr_rsp_id", 32'(r_id[nr+i]), 32'(exp_g[i]));
      chk("rr_hits", 32'(r_hits[nr+i]), 32'(exp_h[i]));
      chk("rr_rsp_latency", 32'(r_cyc[nr+i] - g_cyc[n0+i]), 32'd11);
      if (i < 4) chk("rr_period", 32'(g_cyc[n0+i+1] - g_cyc[n0+i]), 32'd12);
    end

    // Backpressure: pointer is at 1, so 2 wins over 3
    cyc();
    bus.rsp_ready = 1'b0;
    bus.req_data[23:16] = 8'h3C; bus.req_data[31:24] = 8'h81;
    n0 = g_id.size(); nr = r_id.size();
    bus.req_valid = 4'b1100;
    wait_grant(n0 + 1, "bp");
    chk("bp_grant", 32'(g_id[n0]), 32'd2);
    k = 0;
    while (!bus.rsp_valid && k < 40) begin cyc(); k++; end
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_id", 32'(bus.rsp_id), 32'd2);
      chk("bp_hold_hits", 32'(bus.rsp_hits), 32'd4);
      chk("bp_hold_busy", 32'(bus.busy), 32'd1);
      chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    wait_grant(n0 + 2, "bp2");
    chk("bp_second_grant", 32'(g_id[n0+1]), 32'd3);
    chk("bp_accept_after_hs", 32'(g_cyc[n0+1] - r_cyc[nr]), 32'd1);
    wait_rsp(nr + 2, "bp2");
    chk("bp_second_hits", 32'(r_hits[nr+1]), 32'd2);

    // Reset during the 4th SHIFT cycle discards the word
    cyc();
    n0 = g_id.size();
    bus.req_data[7:0] = 8'hFF; bus.req_valid = 4'b0001;
    wait_grant(n0 + 1, "mr");
    repeat (4) cyc();
    reset = 1'b1;
    #1;
    chk("mr_det_reset", 32'(bus.det_reset), 32'd1);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mr_det_data_in", 32'(bus.det_data_in), 32'd0);
    chk("mr_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("mr_rsp_hits", 32'(bus.rsp_hits), 32'd0);
    nr = r_id.size();
    cyc();
    reset = 1'b0;
    repeat (15) cyc();
    chk("mr_no_rsp", 32'(r_id.size()), 32'(nr));
    n0 = g_id.size();
    bus.req_data[7:0] = 8'h0B; bus.req_data[31:24] = 8'hF0;
    bus.req_valid = 4'b1001;
    wait_grant(n0 + 2, "mr2");
    chk("mr_grant_ptr0", 32'(g_id[n0]), 32'd0);
    chk("mr_grant_next", 32'(g_id[n0+1]), 32'd3);
    wait_rsp(nr + 2, "mr2");
    chk("mr_hits0", 32'(r_hits[nr]), 32'd3);
    chk("mr_hits1", 32'(r_hits[nr+1]), 32'd4);

    // Pointer skip: only 2, then only 1; pointer ends at 2
    n0 = g_id.size(); nr = r_id.size();
    bus.req_data[23:16] = 8'h55; bus.req_valid = 4'b0100;
    wait_grant(n0 + 1, "ps");
    bus.req_data[15:8] = 8'hAA; bus.req_valid = 4'b0010;
    wait_grant(n0 + 2, "ps2");
    chk("ps_grant_a", 32'(g_id[n0]), 32'd2);
    chk("ps_grant_b", 32'(g_id[n0+1]), 32'd1);
    wait_rsp(nr + 2, "ps");
    chk("ps_busy_idle", 32'(bus.busy), 32'd0);
    bus.req_valid = 4'hF;
    #1 chk("ps_rr_ptr", 32'(bus.req_ready), 32'h4);
    bus.req_valid = '0;
    cyc();

    // Saturation on the 2-bit-counter instance
    sbus.req_data[7:0] = 8'hFF; sbus.rsp_ready = 1'b1; sbus.req_valid = 2'b01;
    cyc();
    sbus.req_valid = '0;
    chk("sat_busy", 32'(sbus.busy), 32'd1);
    k = 0;
    while (!sbus.rsp_valid && k < 40) begin cyc(); k++; end
    chk("sat_rsp_valid", 32'(sbus.rsp_valid), 32'd1);
    chk("sat_rsp_id", 32'(sbus.rsp_id), 32'd0);
    chk("sat_rsp_hits", 32'(sbus.rsp_hits), 32'd3);
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
